// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// Iterative multiply/divide controller for the 5-stage pipeline. A MULT,
// MULTU, DIV or DIVU sitting in Execute is latched while the unit is idle.
// The unit then runs a shared WIDTH-step datapath:
//   - shift-add for multiplication
//   - restoring subtraction for division
// After the last step it applies the sign fixup and commits to HI/LO.
// While an operation is in flight, a new muldiv op or an MFHI/MFLO in
// Execute causes a stall request.
//
// Build option:
//   MULDIV_EARLY_OUT_EN - multiplications leave RUN as soon as the remaining
//                         multiplier bits are all zero. The accumulator is
//                         then realigned with one barrel shift in FIXUP.
//                         Division always runs the full WIDTH steps.
//
// Ports:
//   clk        pipeline clock
//   reset      synchronous, active-high reset
//   StartE     muldiv op occupies Execute
//   OpE        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcAE      rs value (multiplicand / dividend), already forwarded
//   SrcBE      rt value (multiplier / divisor), already forwarded
//   ReadHiLoE  MFHI or MFLO occupies Execute
//   StallMD    stall request to the hazard unit
//   Busy       an operation is in progress
//   Done       one-cycle pulse in the commit (FIXUP) cycle
//   HI, LO     architectural HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             ReadHiLoE,
  output logic             StallMD,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [CNTW-1:0]  count;

  // Working accumulator.
  //   Multiply: {accHi, accLo} = {partial product, remaining multiplier}.
  //   Divide:   accHi = remainder, accLo = dividend/quotient.
  // operand holds the multiplicand or the divisor.
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic             isDiv;
  logic             negRes;
  logic             negRem;
  logic             divZero;

  // Operand decode: the datapath works on magnitudes, and the signs are
  // remembered for the fixup cycle. Only the sign of the dividend decides
  // the remainder sign.
  logic             opSigned;
  logic             opDiv;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  always_comb begin
    opSigned = ~OpE[0];
    opDiv    = OpE[1];
    signA    = opSigned & SrcAE[WIDTH-1];
    signB    = opSigned & SrcBE[WIDTH-1];
    magA     = signA ? -SrcAE : SrcAE;
    magB     = signB ? -SrcBE : SrcBE;
  end

  // One datapath step of each kind, computed every cycle.
  //
  // Multiply:
  //   The add keeps its carry (WIDTH+1 bits). The carry becomes the new MSB
  //   of accHi after the right shift.
  //
  // Divide:
  //   The shifted remainder can be WIDTH+1 bits wide. When the trial
  //   subtraction fits, the difference is always below the divisor, so
  //   WIDTH-bit arithmetic gives the kept value exactly.
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   remShift;
  logic             divFits;
  logic [WIDTH-1:0] mulHiNext;
  logic [WIDTH-1:0] mulLoNext;
  logic [WIDTH-1:0] divHiNext;
  logic [WIDTH-1:0] divLoNext;

  always_comb begin
    mulSum   = {1'b0, accHi} + {1'b0, operand};
    remShift = {accHi, accLo[WIDTH-1]};
    divFits  = (remShift >= {1'b0, operand});

    if (accLo[0]) begin
      mulHiNext = mulSum[WIDTH:1];
      mulLoNext = {mulSum[0], accLo[WIDTH-1:1]};
    end else begin
      mulHiNext = {1'b0, accHi[WIDTH-1:1]};
      mulLoNext = {accHi[0], accLo[WIDTH-1:1]};
    end

    divHiNext = divFits ? (remShift[WIDTH-1:0] - operand) : remShift[WIDTH-1:0];
    divLoNext = {accLo[WIDTH-2:0], divFits};
  end

  // RUN exit condition.
  //
  // Normally the exit is the last step. With early-out enabled, a multiply
  // also exits once the multiplier bits not yet consumed (the ones above the
  // bit used in this step) are all zero. No further add could happen, so
  // the remaining steps would only shift.
  logic lastStep;
  logic runExit;

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNTW:0]    shAmt;
  logic [WIDTH-1:0] remainMask;
  logic             mulEarly;

  always_comb begin
    lastStep   = (count == CNTW'(WIDTH - 1));
    shAmt      = {1'b0, count} + (CNTW + 1)'(1);
    remainMask = {WIDTH{1'b1}} >> shAmt;
    mulEarly   = ~isDiv & (((accLo >> 1) & remainMask) == '0);
    runExit    = lastStep | mulEarly;
  end
`else
  always_comb begin
    lastStep = (count == CNTW'(WIDTH - 1));
    runExit  = lastStep;
  end
`endif

  // Fixup and commit values.
  //
  // Multiply:
  //   The 2*WIDTH product is negated as a whole. After an early exit,
  //   count still holds the last step executed. The accumulator is short
  //   of WIDTH-1-count right shifts, and those are applied here.
  //
  // Divide:
  //   The quotient and the remainder are negated independently.
  //   For a zero divisor, the quotient is forced to all ones and its sign
  //   is left alone. The remainder then equals the dividend magnitude, so
  //   restoring its sign returns the dividend exactly as presented.
  logic [2*WIDTH-1:0] prodRaw;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNTW-1:0] alignShift;

  always_comb begin
    alignShift = CNTW'(WIDTH - 1) - count;
    prodRaw    = {accHi, accLo} >> alignShift;
  end
`else
  always_comb begin
    prodRaw = {accHi, accLo};
  end
`endif

  always_comb begin
    prodFix = negRes ? -prodRaw : prodRaw;
    fixHi   = prodFix[2*WIDTH-1:WIDTH];
    fixLo   = prodFix[WIDTH-1:0];
    if (isDiv) begin
      fixHi = negRem ? -accHi : accHi;
      if (divZero) begin
        fixLo = '1;
      end else begin
        fixLo = negRes ? -accLo : accLo;
      end
    end
  end

  // State register. Reset drops any operation in flight straight back to
  // IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and status outputs.
  //
  // StallMD depends only on the registered state and two decode strobes.
  // Operand values never reach the hazard unit through this path, and an
  // op presented while idle is accepted without stalling.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (StartE) stateNext = RUN;
      RUN:     if (runExit) stateNext = FIXUP;
      FIXUP:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    Busy    = (state != IDLE);
    Done    = (state == FIXUP);
    StallMD = Busy & (StartE | ReadHiLoE);
  end

  // Datapath and architectural registers.
  //
  // Operands are captured only in IDLE. A StartE seen while busy is being
  // stalled, so it is ignored here and is picked up again once the unit
  // is idle.
  //
  // HI/LO change only at the end of FIXUP. A reset clears them rather
  // than leaving a partial result behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (StartE) begin
            count   <= '0;
            accHi   <= '0;
            isDiv   <= opDiv;
            negRes  <= signA ^ signB;
            negRem  <= signA;
            divZero <= opDiv & (SrcBE == '0);
            if (opDiv) begin
              accLo   <= magA;
              operand <= magB;
            end else begin
              accLo   <= magB;
              operand <= magA;
            end
          end
        end

        RUN: begin
          if (isDiv) begin
            accHi <= divHiNext;
            accLo <= divLoNext;
          end else begin
            accHi <= mulHiNext;
            accLo <= mulLoNext;
          end
          // count is held on exit so FIXUP knows how many steps ran.
          if (!runExit) begin
            count <= count + CNTW'(1);
          end
        end

        FIXUP: begin
          hiReg <= fixHi;
          loReg <= fixLo;
          count <= '0;
        end

        default: begin
          count <= '0;
        end
      endcase
    end
  end

  assign HI = hiReg;
  assign LO = loReg;

endmodule
